// File: rtl/clk_tick_gen_if.sv
// Control/status bundle for the multi-channel tick generator.
// Latency: none (wires only); every output it carries is a registered output of the generator.
// Backpressure: none, the outputs are free-running and are valid every cycle.
// Ports (by modport):
//   master : drives ch_en, sync_clr, div_load, div_sel, div_value; observes tick, clk_out, scan_ctl
//   slave  : the generator side, the same signals in the opposite direction
interface clk_tick_gen_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 27,
  parameter int SCAN_W = 2
);
  // A one-channel build still needs a real select bit.
  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0] ch_en;      // per-channel enable
  logic              sync_clr;   // phase-align every channel
  logic              div_load;   // one-cycle divisor write strobe
  logic [SEL_W-1:0]  div_sel;    // channel targeted by div_load
  logic [CNT_W-1:0]  div_value;  // new tick period in clk cycles (0 = stop)
  logic [NUM_CH-1:0] tick;       // one-cycle pulse at terminal count
  logic [NUM_CH-1:0] clk_out;    // square wave, toggles on every tick
  logic [SCAN_W-1:0] scan_ctl;   // display digit-scan select

  modport master (
    output ch_en, sync_clr, div_load, div_sel, div_value,
    input  tick, clk_out, scan_ctl
  );

  modport slave (
    input  ch_en, sync_clr, div_load, div_sel, div_value,
    output tick, clk_out, scan_ctl
  );
endinterface

// File: rtl/clk_tick_gen.sv
// Multi-channel programmable clock-enable / square-wave generator with a display scan counter.
// Latency: tick/clk_out/scan_ctl are registered; a channel's first tick lands D edges after
//          reset release, re-enable or sync_clr. Backpressure: none, outputs are free-running.
// Ports:
//   clk    : system (crystal) clock
//   rst_n  : asynchronous active-low reset for every flop
//   bus    : clk_tick_gen_if.slave -- ch_en, sync_clr, div_load/div_sel/div_value in;
//            tick, clk_out, scan_ctl out
module clk_tick_gen #(
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = 27,
  parameter int DEF_DIV  = 25000,
  parameter int SCAN_W   = 2,
  parameter int SCAN_DIV = 100000
) (
  input  logic          clk,
  input  logic          rst_n,
  clk_tick_gen_if.slave bus
);

  // SCAN_DIV = 1 would give a zero-width counter, keep at least one bit.
  localparam int               SC_W      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] DIV_RST   = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [SC_W-1:0]  SCAN_LAST = SC_W'(SCAN_DIV - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0]  cnt_q  [NUM_CH];
  logic [CNT_W-1:0]  cnt_d  [NUM_CH];
  logic [CNT_W-1:0]  div_q  [NUM_CH];   // divisor in use
  logic [CNT_W-1:0]  div_d  [NUM_CH];
  logic [CNT_W-1:0]  pend_q [NUM_CH];   // divisor waiting for a safe switch point
  logic [CNT_W-1:0]  pend_d [NUM_CH];
  logic [NUM_CH-1:0] pend_vld_q, pend_vld_d;
  logic [NUM_CH-1:0] tick_q, tick_d;
  logic [NUM_CH-1:0] clk_out_q, clk_out_d;
  logic [SC_W-1:0]   scan_cnt_q, scan_cnt_d;
  logic [SCAN_W-1:0] scan_ctl_q, scan_ctl_d;

  // Per-channel decode of the current cycle
  logic [NUM_CH-1:0] load_hit;   // div_load addresses this channel
  logic [NUM_CH-1:0] term_hit;   // running and at the last count of the period
  logic [NUM_CH-1:0] idle;       // disabled or stopped (div = 0)

  always_comb begin
    load_hit = '0;
    term_hit = '0;
    idle     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      // An out-of-range div_sel matches no channel, so the write is dropped.
      load_hit[i] = bus.div_load && (int'(bus.div_sel) == i);
      idle[i]     = !bus.ch_en[i] || (div_q[i] == '0);
      term_hit[i] = (div_q[i] != '0) && (cnt_q[i] == div_q[i] - CNT_ONE);
    end
  end

  // ---------------------------------------------------------------------------
  // Divider channels
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_d      = cnt_q;
    div_d      = div_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    tick_d     = '0;
    clk_out_d  = clk_out_q;

    for (int i = 0; i < NUM_CH; i++) begin
      if (bus.sync_clr) begin
        // Phase-align: everything restarts from zero. A divisor written in the
        // same cycle is taken straight into use so the aligned period already
        // runs at the new rate; otherwise any queued divisor is committed.
        cnt_d[i]     = '0;
        clk_out_d[i] = 1'b0;
        if (load_hit[i]) begin
          div_d[i]  = bus.div_value;
          pend_d[i] = bus.div_value;
        end else if (pend_vld_q[i]) begin
          div_d[i] = pend_q[i];
        end
        pend_vld_d[i] = 1'b0;
      end else begin
        if (idle[i]) begin
          // Nothing is mid-period, so a queued divisor can switch in now.
          cnt_d[i] = '0;
          if (!bus.ch_en[i]) begin
            clk_out_d[i] = 1'b0;
          end
          if (pend_vld_q[i]) begin
            div_d[i]      = pend_q[i];
            pend_vld_d[i] = 1'b0;
          end
        end else if (term_hit[i]) begin
          // End of period: the only glitch-free point to change the divisor.
          tick_d[i]    = 1'b1;
          clk_out_d[i] = ~clk_out_q[i];
          cnt_d[i]     = '0;
          if (pend_vld_q[i]) begin
            div_d[i]      = pend_q[i];
            pend_vld_d[i] = 1'b0;
          end
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end

        // Applied after the commit above: a write landing on a terminal count
        // stays queued for the next one, and a newer write replaces an older one.
        if (load_hit[i]) begin
          pend_d[i]     = bus.div_value;
          pend_vld_d[i] = 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Display scan counter: free-running, independent of ch_en and sync_clr
  // ---------------------------------------------------------------------------
  always_comb begin
    scan_cnt_d = scan_cnt_q + SC_W'(1);
    scan_ctl_d = scan_ctl_q;
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d = '0;
      scan_ctl_d = scan_ctl_q + SCAN_W'(1);   // wraps naturally at 2^SCAN_W
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]  <= '0;
        div_q[i]  <= DIV_RST;
        pend_q[i] <= DIV_RST;
      end
      pend_vld_q <= '0;
      tick_q     <= '0;
      clk_out_q  <= '0;
      scan_cnt_q <= '0;
      scan_ctl_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      tick_q     <= tick_d;
      clk_out_q  <= clk_out_d;
      scan_cnt_q <= scan_cnt_d;
      scan_ctl_q <= scan_ctl_d;
    end
  end

  assign bus.tick     = tick_q;
  assign bus.clk_out  = clk_out_q;
  assign bus.scan_ctl = scan_ctl_q;

endmodule
